// File: rtl/dmac_ahb_pkg.sv
// Shared AHB-Lite types for the DMA channel controller and the target-side
// responder model.
//   htrans_t      : HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ)
//   hresp_t       : HRESP encodings (OKAY, ERROR)
//   slave_state_t : responder data-phase FSM states
package dmac_ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } slave_state_t;

    // Wait-state counter width; covers WAIT_CYCLES up to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/dmac_slave_mem.sv
// Word memory behind the AHB responder: DEPTH x 32 register array with a
// synchronous write port and an asynchronous read port sharing one address.
// Contents are neither reset nor initialised.
//   clk   : clock
//   we    : write enable, commits wdata at the rising edge
//   addr  : word index for both read and write
//   wdata : write data
//   rdata : combinational read of mem[addr]
module dmac_slave_mem
    import dmac_ahb_pkg::*;
#(
    parameter int DEPTH = 256,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/dmac_ahb_slave.sv
// AHB-Lite responder terminating DMA master transfers against an internal
// word memory, with WAIT_CYCLES wait states per OKAY data phase.
// Optional macro DMAC_AHB_SLAVE_ERR_EN: out-of-range or unaligned accesses
// get the two-cycle ERROR response and never touch memory. Without it the
// index wraps modulo DEPTH, HAddr[1:0] is ignored and HResp stays OKAY.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   HSel, HTrans,
//   HWrite, HAddr     : address phase
//   HWData            : write data (data phase)
//   HReady            : bus ready (previous transfer complete)
//   HRData            : read data, 0 outside a read data phase
//   HReadyOut, HResp  : responder ready / response
module dmac_ahb_slave
    import dmac_ahb_pkg::*;
#(
    parameter int          DEPTH       = 256,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        HSel,
    input  logic [1:0]  HTrans,
    input  logic        HWrite,
    input  logic [31:0] HAddr,
    input  logic [31:0] HWData,
    input  logic        HReady,
    output logic [31:0] HRData,
    output logic        HReadyOut,
    output logic [1:0]  HResp
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    slave_state_t      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [AW-1:0]     idx_q, idx_d;

    logic              accept;
    logic [31:0]       offset;
    logic [AW-1:0]     idx_in;
    logic              mem_we;
    logic [31:0]       mem_rdata;
    hresp_t            hresp;

    assign accept = HSel && HTrans[1] && HReady;
    assign offset = HAddr - ADDR_BASE;
    assign idx_in = offset[AW+1:2];

`ifdef DMAC_AHB_SLAVE_ERR_EN
    // ADDR_BASE is aligned to the region size, so "in range" is simply a
    // match of the address bits above the region.
    logic err_in;
    assign err_in = (HAddr[31:AW+2] != ADDR_BASE[31:AW+2]) || (HAddr[1:0] != 2'b00);
`endif

    logic unused_bits;
    assign unused_bits = ^{offset[31:AW+2], offset[1:0], HTrans[0]};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            idx_q   <= idx_d;
        end
    end

    // Next state; address phase is only taken in states driving HReadyOut=1
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        idx_d   = idx_q;
        case (state_q)
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end
            end
`ifdef DMAC_AHB_SLAVE_ERR_EN
            ST_ERR1: state_d = ST_ERR2;
            ST_IDLE, ST_DATA, ST_ERR2: begin
`else
            ST_IDLE, ST_DATA: begin
`endif
                state_d = ST_IDLE;
                if (accept) begin
                    write_d = HWrite;
                    idx_d   = idx_in;
`ifdef DMAC_AHB_SLAVE_ERR_EN
                    if (err_in) begin
                        state_d = ST_ERR1;
                    end else
`endif
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        HReadyOut = 1'b1;
        hresp     = HRESP_OKAY;
        case (state_q)
            ST_WAIT: HReadyOut = 1'b0;
`ifdef DMAC_AHB_SLAVE_ERR_EN
            ST_ERR1: begin
                HReadyOut = 1'b0;
                hresp     = HRESP_ERROR;
            end
            ST_ERR2: hresp = HRESP_ERROR;
`endif
            default: ;
        endcase
    end

    assign HResp  = hresp;
    assign mem_we = (state_q == ST_DATA) && write_q;
    assign HRData = ((state_q == ST_DATA) && !write_q) ? mem_rdata : 32'h0;

    dmac_slave_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (idx_q),
        .wdata (HWData),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_dmac_ahb_slave.sv
// Directed bench for dmac_ahb_slave: one instance with zero wait states and
// one with three, sharing the address/data bus; each sees its own HSel and
// has HReady tied back to its own HReadyOut.
module tb_dmac_ahb_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel0, hsel3;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] haddr, hwdata;
    logic [31:0] hrdata0, hrdata3;
    logic        hro0, hro3;
    logic [1:0]  hresp0, hresp3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmac_ahb_slave #(.DEPTH(256), .ADDR_BASE(32'h0), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .HSel(hsel0), .HTrans(htrans), .HWrite(hwrite),
        .HAddr(haddr), .HWData(hwdata), .HReady(hro0), .HRData(hrdata0),
        .HReadyOut(hro0), .HResp(hresp0)
    );

    dmac_ahb_slave #(.DEPTH(256), .ADDR_BASE(32'h0), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .HSel(hsel3), .HTrans(htrans), .HWrite(hwrite),
        .HAddr(haddr), .HWData(hwdata), .HReady(hro3), .HRData(hrdata3),
        .HReadyOut(hro3), .HResp(hresp3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; sample and drive 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_ph(input logic [1:0] t, input logic w, input logic [31:0] a);
        htrans = t;
        hwrite = w;
        haddr  = a;
    endtask

    task automatic idle();
        htrans = 2'b00;
        hwrite = 1'b0;
    endtask

    initial begin
        rst = 1'b1; hsel0 = 1'b0; hsel3 = 1'b0;
        htrans = 2'b00; hwrite = 1'b0; haddr = '0; hwdata = '0;
        cyc(); cyc();

        // Reset state
        chk("rst_rdy0",   {31'b0, hro0}, 32'd1);
        chk("rst_resp0",  {30'b0, hresp0}, 32'd0);
        chk("rst_rdata0", hrdata0, 32'd0);
        chk("rst_rdy3",   {31'b0, hro3}, 32'd1);
        rst = 1'b0;

        // Zero-wait write then back-to-back read of 0x10
        hsel0 = 1'b1;
        addr_ph(2'b10, 1'b1, 32'h10);
        cyc();
        chk("t1_wr_rdy", {31'b0, hro0}, 32'd1);
        hwdata = 32'hDEAD_BEEF;
        addr_ph(2'b10, 1'b0, 32'h10);
        cyc();
        chk("t1_rd_rdy",  {31'b0, hro0}, 32'd1);
        chk("t1_rd_data", hrdata0, 32'hDEAD_BEEF);
        chk("t1_rd_resp", {30'b0, hresp0}, 32'd0);
        idle();
        cyc();
        chk("t1_idle_rdata", hrdata0, 32'd0);
        chk("t1_idle_rdy",   {31'b0, hro0}, 32'd1);

        // Three wait states: write 0x20 (junk on HWData until final cycle), read back
        hsel0 = 1'b0; hsel3 = 1'b1;
        addr_ph(2'b10, 1'b1, 32'h20);
        cyc();
        idle();
        for (int i = 0; i < 3; i++) begin
            chk("t2_wr_wait", {31'b0, hro3}, 32'd0);
            hwdata = 32'h1111_1111 * (i + 1);
            cyc();
        end
        chk("t2_wr_done", {31'b0, hro3}, 32'd1);
        hwdata = 32'hCAFE_0020;
        addr_ph(2'b10, 1'b0, 32'h20);
        cyc();
        idle();
        for (int i = 0; i < 3; i++) begin
            chk("t2_rd_wait",  {31'b0, hro3}, 32'd0);
            chk("t2_rd_wait_data", hrdata3, 32'd0);
            cyc();
        end
        chk("t2_rd_rdy",  {31'b0, hro3}, 32'd1);
        chk("t2_rd_data", hrdata3, 32'hCAFE_0020);
        cyc();
        chk("t2_idle_rdy", {31'b0, hro3}, 32'd1);

        // Pipelined burst: NONSEQ + 3xSEQ writes of 1..4, then reads
        hsel3 = 1'b0; hsel0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr_ph((i == 0) ? 2'b10 : 2'b11, 1'b1, 32'(i * 4));
            if (i > 0) hwdata = 32'(i);
            cyc();
            chk("t3_wr_rdy", {31'b0, hro0}, 32'd1);
        end
        hwdata = 32'd4;
        addr_ph(2'b10, 1'b0, 32'h0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("t3_rd_rdy",  {31'b0, hro0}, 32'd1);
            chk("t3_rd_data", hrdata0, 32'(i + 1));
            if (i < 3) addr_ph(2'b11, 1'b0, 32'((i + 1) * 4));
            else       idle();
            cyc();
        end

`ifdef DMAC_AHB_SLAVE_ERR_EN
        // Out-of-range and unaligned reads, then an errored write that must not land
        addr_ph(2'b10, 1'b0, 32'h400);
        cyc();
        chk("t4a_err1_rdy",  {31'b0, hro0}, 32'd0);
        chk("t4a_err1_resp", {30'b0, hresp0}, 32'd1);
        idle();
        cyc();
        chk("t4a_err2_rdy",  {31'b0, hro0}, 32'd1);
        chk("t4a_err2_resp", {30'b0, hresp0}, 32'd1);
        chk("t4a_err2_data", hrdata0, 32'd0);
        addr_ph(2'b10, 1'b0, 32'h2);
        cyc();
        chk("t4b_err1_rdy",  {31'b0, hro0}, 32'd0);
        chk("t4b_err1_resp", {30'b0, hresp0}, 32'd1);
        idle();
        cyc();
        chk("t4b_err2_rdy",  {31'b0, hro0}, 32'd1);
        chk("t4b_err2_resp", {30'b0, hresp0}, 32'd1);
        addr_ph(2'b10, 1'b1, 32'h400);
        cyc();
        hwdata = 32'h0000_0BAD;
        idle();
        cyc();
        cyc();
        chk("t4_idle_resp", {30'b0, hresp0}, 32'd0);
        addr_ph(2'b10, 1'b0, 32'h0);
        cyc();
        chk("t4_word0_kept", hrdata0, 32'd1);
        chk("t4_word0_resp", {30'b0, hresp0}, 32'd0);
        idle();
        cyc();
`else
        // Out-of-range write aliases to word 0
        addr_ph(2'b10, 1'b1, 32'h400);
        cyc();
        chk("t4_alias_rdy",  {31'b0, hro0}, 32'd1);
        chk("t4_alias_resp", {30'b0, hresp0}, 32'd0);
        hwdata = 32'hA5A5_0000;
        addr_ph(2'b10, 1'b0, 32'h0);
        cyc();
        chk("t4_alias_data", hrdata0, 32'hA5A5_0000);
        chk("t4_alias_rresp", {30'b0, hresp0}, 32'd0);
        idle();
        cyc();
`endif

        // Reset in the second wait cycle drops the pending write to 0x30
        hsel0 = 1'b0; hsel3 = 1'b1;
        hwdata = 32'h0000_3030;
        addr_ph(2'b10, 1'b1, 32'h30);
        cyc();
        idle();
        repeat (3) cyc();
        cyc();
        addr_ph(2'b10, 1'b1, 32'h30);
        hwdata = 32'hFFFF_3030;
        cyc();
        chk("t5_wait1_rdy", {31'b0, hro3}, 32'd0);
        idle();
        cyc();
        rst = 1'b1;
        cyc();
        chk("t5_rst_rdy",   {31'b0, hro3}, 32'd1);
        chk("t5_rst_resp",  {30'b0, hresp3}, 32'd0);
        chk("t5_rst_rdata", hrdata3, 32'd0);
        rst = 1'b0;
        cyc();
        chk("t5_post_rdy", {31'b0, hro3}, 32'd1);
        addr_ph(2'b10, 1'b0, 32'h30);
        cyc();
        idle();
        repeat (3) cyc();
        chk("t5_rd_rdy",  {31'b0, hro3}, 32'd1);
        chk("t5_rd_old",  hrdata3, 32'h0000_3030);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
